// File: rtl/ssq_fifo.sv
// Slave-select queue: circular-buffer FIFO with occupancy count, threshold flags,
// flush and sticky overflow/underflow error reporting.
module ssq_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              rd_acc;
    logic              wr_acc;

    // A full queue still accepts a write when a read frees a slot the same edge.
    assign rd_acc = rd_en & (count_q != '0);
    assign wr_acc = wr_en & ((count_q != CW'(DEPTH)) | rd_acc);

    // Storage carries no reset so it can map onto plain register/RAM cells.
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A new error in the same cycle as err_clr keeps the flag set.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));
    assign almost_full  = (count_q >= CW'(AFULL_TH));

endmodule

// File: tb/tb_ssq_fifo.sv
// Bench for ssq_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ssq_fifo;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 14;
    localparam int AEMPTY_TH = 2;

    logic              clk = 1'b0;
    logic              reset, flush, wr_en, rd_en, err_clr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, empty, full, almost_empty, almost_full;
    logic              overflow, underflow;
    logic [4:0]        count;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    // Reference model state
    logic [DATA_W-1:0] q [$];
    logic [DATA_W-1:0] m_rd_data;
    logic              m_rd_valid, m_ovf, m_unf;

    ssq_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit can_rd, can_wr;
        if (reset) begin
            q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rd_valid = 1'b0;
        end else begin
            can_rd = rd_en && (q.size() > 0);
            can_wr = wr_en && ((q.size() < DEPTH) || can_rd);
            if (wr_en && !can_wr) m_ovf = 1'b1;
            else if (err_clr)     m_ovf = 1'b0;
            if (rd_en && !can_rd) m_unf = 1'b1;
            else if (err_clr)     m_unf = 1'b0;
            m_rd_valid = can_rd;
            if (can_rd) m_rd_data = q.pop_front();
            if (can_wr) q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rd_data",      rd_data,      m_rd_data);
            chk("rd_valid",     rd_valid,     m_rd_valid);
            chk("count",        count,        q.size());
            chk("empty",        empty,        q.size() == 0);
            chk("full",         full,         q.size() == DEPTH);
            chk("almost_empty", almost_empty, q.size() <= AEMPTY_TH);
            chk("almost_full",  almost_full,  q.size() >= AFULL_TH);
            chk("overflow",     overflow,     m_ovf);
            chk("underflow",    underflow,    m_unf);
        end
    end

    // One clock cycle with the given inputs; returns just after the falling edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic f, input logic ec, input logic rs);
        wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec; reset = rs;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        wr_data = '0;
        @(posedge clk);
        @(negedge clk);
        started = 1'b1;
        step(0, 8'h00, 0, 0, 0, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_rd_data", rd_data, 0);

        // Fill to full, almost_full rising on the 14th write
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 0, 0, 0, 0);
            if (i == 13) chk("afull_at_13", almost_full, 0);
            if (i == 14) chk("afull_at_14", almost_full, 1);
        end
        chk("full_count", count, 16);
        chk("full_flag", full, 1);
        step(1, 8'hAA, 0, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);

        // Full queue with simultaneous read and write
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'h55, 1, 0, 0, 0);
            chk("fullrw_data", rd_data, i);
            chk("fullrw_valid", rd_valid, 1);
            chk("fullrw_count", count, 16);
        end
        chk("fullrw_ovf", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 0, 0);
            chk("drain_data", rd_data, 8'h55);
            chk("drain_valid", rd_valid, 1);
        end
        chk("drain_empty", empty, 1);

        // Empty queue with simultaneous read and write: no bypass
        step(0, 8'h00, 0, 0, 1, 0);
        chk("ovf_cleared", overflow, 0);
        step(1, 8'h3C, 1, 0, 0, 0);
        chk("emptyrw_unf", underflow, 1);
        chk("emptyrw_valid", rd_valid, 0);
        chk("emptyrw_count", count, 1);
        step(0, 8'h00, 1, 0, 0, 0);
        chk("emptyrw_data", rd_data, 8'h3C);
        chk("emptyrw_rv", rd_valid, 1);

        // Pointer wrap
        step(0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 8'h00, 1, 0, 0, 0);
            chk("wrap_data", rd_data, 8'h20 + i);
        end
        chk("wrap_count", count, 0);

        // Flush with concurrent requests
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
        step(1, 8'hEE, 1, 1, 0, 0);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_valid", rd_valid, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_unf", underflow, 0);
        step(0, 8'h00, 1, 0, 1, 0);
        chk("clr_vs_set_unf", underflow, 1);

        // Reset while entries are queued and a read is requested
        for (int i = 0; i < 7; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
        chk("pre_rst_count", count, 7);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("midrst_count", count, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_data", rd_data, 0);
        chk("midrst_unf", underflow, 0);
        step(0, 8'h00, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ssq_fifo.md
# ssq_fifo

Parametrised, fully synchronous slave-select queue for the AXI4-Lite to SPI bridge. It buffers target slave addresses (or other per-transaction tags) between the AXI front end and the SPI engine as a circular-buffer FIFO. It adds occupancy count, programmable almost-full/almost-empty thresholds, flush, sticky overflow/underflow error flags and defined simultaneous read/write behaviour at every boundary.

## Interface
- DATA_W, 8, entry width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AFULL_TH, 14, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- flush  in  1  synchronous queue clear, priority below reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  entry to enqueue
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered dequeued entry
- rd_valid  out  1  one-cycle pulse: rd_data updated by an accepted read
- count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AEMPTY_TH
- almost_full  out  1  count ≥ AFULL_TH
- overflow  out  1  sticky: write rejected since last clear
- underflow  out  1  sticky: read rejected since last clear
- err_clr  in  1  clears overflow/underflow

## Operation
- Storage: DEPTH × DATA_W array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap naturally DEPTH-1 → 0; count register separate.
- rd_acc = rd_en & (count != 0). wr_acc = wr_en & ((count != DEPTH) | rd_acc).
- Accepted write: mem[wr_ptr] ← wr_data, wr_ptr+1. Accepted read: rd_data ← mem[rd_ptr], rd_ptr+1, rd_valid=1 next cycle.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Full with rd_en & wr_en: both accepted, count stays DEPTH, no overflow.
- Empty with rd_en & wr_en: write accepted, read rejected (no bypass), count → 1, underflow set.
- wr_en & !wr_acc: overflow ← 1, data dropped, state unchanged. rd_en & !rd_acc: underflow ← 1, rd_data held, rd_valid 0.
- err_clr clears both sticky flags; a set in the same cycle wins (flag stays 1).
- flush: pointers, count → 0; rd_valid → 0; rd_en/wr_en that cycle ignored (no error flags set); memory contents, rd_data and sticky flags untouched.
- reset: pointers, count, rd_data, rd_valid, overflow, underflow → 0; memory need not be cleared. Reset mid-operation discards all queued entries same edge.
- Status outputs decoded combinationally from registered count only; no combinational path from wr_en/rd_en to any output.

## Timing
- Reset values: rd_data 0, rd_valid 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (for AFULL_TH ≥1), overflow 0, underflow 0.
- Write at edge N: count/empty/full update after edge N; earliest accepted read at edge N+1; rd_data/rd_valid visible after edge N+1.
- Read latency: 1 cycle from accepting edge to rd_data. rd_valid high exactly one cycle per accepted read; back-to-back reads give continuous rd_valid.
- Throughput: one write and one read per cycle sustained at any occupancy except empty (reads) / full without read (writes).
- Flags/count reflect post-edge state; sticky errors assert the cycle after the offending request.

## Test plan
- Reset then 16 writes 0x01..0x10 (DEPTH=16) -> count 16, full=1, almost_full from 14th write; 17th write 0xAA -> dropped, overflow=1, count 16.
- Full queue, rd_en & wr_en with 0x55 for 16 cycles -> rd_data 0x01..0x10 in order with rd_valid each cycle, count stays 16, overflow unchanged; then 16 reads return 0x55 ×16, empty=1.
- Empty queue, rd_en & wr_en with 0x3C -> underflow=1, rd_valid=0, count 1; next read returns 0x3C.
- Pointer wrap: 10 writes, 10 reads, 10 writes (0x20..0x29), 10 reads -> data 0x20..0x29 in order, count back to 0.
- Write 5 entries, assert flush with wr_en/rd_en -> count 0, empty=1, no error flags; err_clr with simultaneous rejected read -> underflow remains 1.
- Reset asserted with 7 entries queued and rd_en high -> all outputs at reset values next cycle, no rd_valid.
